uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between NUM_REQ byte-stream requesters using
// packet-locked round-robin arbitration. Once a requester wins, it keeps the
// transmitter until the byte it flagged as last has been handed over. An
// optional source-ID header byte (HEADER_BASE + grant index) precedes every
// packet. A requester that stalls mid-packet for GAP_TIMEOUT cycles loses its
// grant and o_abort pulses.
//
// Ports
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_req_valid     per-requester byte valid               [NUM_REQ]
//   i_req_data      per-requester byte, k at [8k+7:8k]     [8*NUM_REQ]
//   i_req_last      byte is the last of its packet         [NUM_REQ]
//   o_req_ready     byte accepted when valid & ready       [NUM_REQ]
//   o_tx_en         one-cycle load strobe to transmitter
//   o_tx_data       byte to transmitter, held between strobes
//   i_tx_rd         transmitter idle / ready for a new byte
//   o_grant         one-hot current owner, 0 when idle     [NUM_REQ]
//   o_busy          high in every state except ARB
//   o_abort         one-cycle pulse when a packet is abandoned on timeout
//
// Every output is either a register or a decode of registers only, so no
// input reaches an output combinationally.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int         NUM_REQ     = 4,
  parameter bit         HEADER_EN   = 1'b1,
  parameter logic [7:0] HEADER_BASE = 8'hA0,
  parameter int         GAP_TIMEOUT = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic                 o_tx_en,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_rd,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_busy,
  output logic                 o_abort
);

  localparam int PW = $clog2(NUM_REQ);
  // The gap counter only has to reach GAP_TIMEOUT-1: the abort decision is
  // taken in the cycle the count would otherwise hit GAP_TIMEOUT.
  localparam int CW = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;
  localparam logic [CW-1:0] GAP_LAST = (GAP_TIMEOUT > 0) ? CW'(GAP_TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_ARB,    // pick the next owner
    S_LOAD,   // accept exactly one byte from the owner
    S_SEND,   // wait for the transmitter, then strobe
    S_GUARD,  // skip the transmitter's stale ready right after a load
    S_WAIT    // wait until the byte has been taken
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [PW-1:0]        gidx_q, gidx_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [7:0]           hold_byte_q, hold_byte_d;
  logic                 hold_last_q, hold_last_d;
  logic [CW-1:0]        gap_q, gap_d;
  logic                 tx_en_q, tx_en_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 abort_q, abort_d;

  logic                 arb_found;
  logic [PW-1:0]        arb_idx;

  // (base + offs) mod NUM_REQ for offs < NUM_REQ; works for non-power-of-2.
  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PW'(s);
  endfunction

  // Round-robin scan starting at ptr_q; first asserted valid wins.
  always_comb begin
    // NOTE: every variable written here gets a default before any branch,
    // otherwise paths that skip an assignment would infer a latch.
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!arb_found && i_req_valid[rr_index(ptr_q, i)]) begin
        arb_found = 1'b1;
        arb_idx   = rr_index(ptr_q, i);
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    hold_byte_d = hold_byte_q;
    hold_last_d = hold_last_q;
    gap_d       = gap_q;
    tx_en_d     = 1'b0;       // strobe is single-cycle by default
    tx_data_d   = tx_data_q;  // data is held between strobes
    abort_d     = 1'b0;

    unique case (state_q)
      S_ARB: begin
        if (arb_found) begin
          grant_d          = '0;
          grant_d[arb_idx] = 1'b1;
          gidx_d           = arb_idx;
          ptr_d            = (arb_idx == PW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          gap_d            = '0;
          if (HEADER_EN) begin
            hold_byte_d = HEADER_BASE + 8'(arb_idx);
            hold_last_d = 1'b0;
            state_d     = S_SEND;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        // A valid byte beats a timeout landing in the same cycle.
        if (i_req_valid[gidx_q]) begin
          hold_byte_d = i_req_data[8*gidx_q +: 8];
          hold_last_d = i_req_last[gidx_q];
          state_d     = S_SEND;
        end else if (GAP_TIMEOUT > 0) begin
          if (gap_q == GAP_LAST) begin
            abort_d = 1'b1;
            grant_d = '0;
            state_d = S_ARB;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end

      S_SEND: begin
        if (i_tx_rd) begin
          tx_en_d   = 1'b1;
          tx_data_d = hold_byte_q;
          state_d   = S_GUARD;
        end
      end

      S_GUARD: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (i_tx_rd) begin
          if (hold_last_q) begin
            grant_d = '0;
            state_d = S_ARB;
          end else begin
            gap_d   = '0;
            state_d = S_LOAD;
          end
        end
      end

      default: begin
        grant_d = '0;
        state_d = S_ARB;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_ARB;
      grant_q     <= '0;
      gidx_q      <= '0;
      ptr_q       <= '0;
      hold_byte_q <= '0;
      hold_last_q <= 1'b0;
      gap_q       <= '0;
      tx_en_q     <= 1'b0;
      tx_data_q   <= 8'h00;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      hold_byte_q <= hold_byte_d;
      hold_last_q <= hold_last_d;
      gap_q       <= gap_d;
      tx_en_q     <= tx_en_d;
      tx_data_q   <= tx_data_d;
      abort_q     <= abort_d;
    end
  end

  assign o_req_ready = (state_q == S_LOAD) ? grant_q : '0;
  assign o_tx_en     = tx_en_q;
  assign o_tx_data   = tx_data_q;
  assign o_grant     = grant_q;
  assign o_busy      = (state_q != S_ARB);
  assign o_abort     = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter (NUM_REQ=4, HEADER_BASE=A0, HEADER_EN=1,
// GAP_TIMEOUT=16). Requesters are fed from per-requester byte FIFOs, the
// transmitter is modelled as busy for 20 cycles after each strobe, and every
// strobe is matched against a scoreboard of expected (byte, grant) pairs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NR      = 4;
  localparam int TX_BUSY = 20;
  localparam int QD      = 64;

  logic            i_clk;
  logic            i_rst_n;
  logic [NR-1:0]   i_req_valid;
  logic [8*NR-1:0] i_req_data;
  logic [NR-1:0]   i_req_last;
  logic [NR-1:0]   o_req_ready;
  logic            o_tx_en;
  logic [7:0]      o_tx_data;
  logic            i_tx_rd;
  logic [NR-1:0]   o_grant;
  logic            o_busy;
  logic            o_abort;

  uart_tx_arbiter #(
    .NUM_REQ     (NR),
    .HEADER_EN   (1'b1),
    .HEADER_BASE (8'hA0),
    .GAP_TIMEOUT (16)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .i_req_last  (i_req_last),
    .o_req_ready (o_req_ready),
    .o_tx_en     (o_tx_en),
    .o_tx_data   (o_tx_data),
    .i_tx_rd     (i_tx_rd),
    .o_grant     (o_grant),
    .o_busy      (o_busy),
    .o_abort     (o_abort)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // ---------------------------------------------------------------- checking
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0]    data;
    logic [NR-1:0] grant;
  } exp_t;

  exp_t sb[$];

  task automatic push_exp(input logic [7:0] d, input logic [NR-1:0] g);
    exp_t e;
    e.data  = d;
    e.grant = g;
    sb.push_back(e);
  endtask

  // ---------------------------------------------------------- requester FIFOs
  logic [7:0] rq_data [NR][QD];
  logic       rq_last [NR][QD];
  int         rq_head [NR];
  int         rq_tail [NR];
  logic       rq_pend [NR];

  task automatic enq(input int k, input logic [7:0] d, input logic l);
    rq_data[k][rq_tail[k]] = d;
    rq_last[k][rq_tail[k]] = l;
    rq_tail[k]++;
  endtask

  task automatic flush_reqs();
    for (int k = 0; k < NR; k++) begin
      rq_head[k] = rq_tail[k];
      rq_pend[k] = 1'b0;
    end
  endtask

  // Requester drivers: present the FIFO head on the falling edge; a byte seen
  // with valid & ready here is taken on the next rising edge and popped one
  // falling edge later.
  initial begin
    i_req_valid = '0;
    i_req_data  = '0;
    i_req_last  = '0;
    for (int k = 0; k < NR; k++) begin
      rq_head[k] = 0;
      rq_tail[k] = 0;
      rq_pend[k] = 1'b0;
    end
    forever begin
      @(negedge i_clk);
      for (int k = 0; k < NR; k++) begin
        if (rq_pend[k]) begin
          rq_head[k]++;
          rq_pend[k] = 1'b0;
        end
        if (rq_head[k] != rq_tail[k]) begin
          i_req_valid[k]       = 1'b1;
          i_req_data[8*k +: 8] = rq_data[k][rq_head[k]];
          i_req_last[k]        = rq_last[k][rq_head[k]];
        end else begin
          i_req_valid[k]       = 1'b0;
          i_req_data[8*k +: 8] = 8'h00;
          i_req_last[k]        = 1'b0;
        end
        if (i_req_valid[k] && o_req_ready[k]) rq_pend[k] = 1'b1;
      end
    end
  end

  // ------------------------------------------- transmitter model + monitor
  int tx_cnt   = 0;
  bit tx_block = 1'b0;
  int strobes  = 0;
  int aborts   = 0;

  initial begin
    exp_t e;
    i_tx_rd = 1'b1;
    forever begin
      @(negedge i_clk);
      if (o_abort === 1'b1) aborts++;
      if (o_tx_en === 1'b1) begin
        strobes++;
        check("tx_rd_at_strobe", 32'(i_tx_rd), 32'd1);
        check("strobe_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("tx_data", 32'(o_tx_data), 32'(e.data));
          check("grant_at_strobe", 32'(o_grant), 32'(e.grant));
        end
        tx_cnt = TX_BUSY;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
      end
      i_tx_rd = (tx_cnt == 0) && !tx_block;
    end
  end

  // ------------------------------------------------------------- main steps
  task automatic wait_idle(input int limit, input string tag);
    bit done;
    done = 1'b0;
    for (int c = 0; c < limit && !done; c++) begin
      @(negedge i_clk);
      #1;
      if (sb.size() == 0 && o_busy === 1'b0) done = 1'b1;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_grant(input int limit, input logic [NR-1:0] g, input string tag);
    bit done;
    done = 1'b0;
    for (int c = 0; c < limit && !done; c++) begin
      @(negedge i_clk);
      #1;
      if (o_grant === g) done = 1'b1;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(o_req_ready), 32'd0);
    check({tag, "_tx_en"}, 32'(o_tx_en), 32'd0);
    check({tag, "_tx_data"}, 32'(o_tx_data), 32'd0);
    check({tag, "_grant"}, 32'(o_grant), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_abort"}, 32'(o_abort), 32'd0);
  endtask

  initial begin
    int s0;
    int a0;
    int n;
    bit found;

    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    #1;
    check_all_zero("reset");
    i_rst_n = 1'b1;

    // Single packet from req2 with header.
    s0 = strobes;
    push_exp(8'hA2, 4'b0100);
    push_exp(8'h11, 4'b0100);
    push_exp(8'h22, 4'b0100);
    enq(2, 8'h11, 1'b0);
    enq(2, 8'h22, 1'b1);
    wait_idle(500, "single_idle");
    check("single_strobes", 32'(strobes - s0), 32'd3);
    check("single_grant_after", 32'(o_grant), 32'd0);
    check("single_busy_after", 32'(o_busy), 32'd0);

    // Restart from a fresh pointer so requester 0 has priority.
    i_rst_n = 1'b0;
    #3;
    i_rst_n = 1'b1;

    // Round-robin among req0, req1, req3 with back-to-back 1-byte packets.
    s0 = strobes;
    push_exp(8'hA0, 4'b0001); push_exp(8'h01, 4'b0001);
    push_exp(8'hA1, 4'b0010); push_exp(8'h11, 4'b0010);
    push_exp(8'hA3, 4'b1000); push_exp(8'h31, 4'b1000);
    push_exp(8'hA0, 4'b0001); push_exp(8'h02, 4'b0001);
    push_exp(8'hA1, 4'b0010); push_exp(8'h12, 4'b0010);
    enq(0, 8'h01, 1'b1); enq(0, 8'h02, 1'b1);
    enq(1, 8'h11, 1'b1); enq(1, 8'h12, 1'b1);
    enq(3, 8'h31, 1'b1);
    wait_idle(1500, "rr_idle");
    check("rr_strobes", 32'(strobes - s0), 32'd10);

    // Packet lock: req0 arrives while req1 is mid-packet.
    s0 = strobes;
    push_exp(8'hA1, 4'b0010);
    push_exp(8'h41, 4'b0010);
    push_exp(8'h42, 4'b0010);
    push_exp(8'h43, 4'b0010);
    push_exp(8'hA0, 4'b0001);
    push_exp(8'h51, 4'b0001);
    enq(1, 8'h41, 1'b0);
    enq(1, 8'h42, 1'b0);
    enq(1, 8'h43, 1'b1);
    wait_grant(50, 4'b0010, "lock_grant1");
    enq(0, 8'h51, 1'b1);
    wait_idle(1000, "lock_idle");
    check("lock_strobes", 32'(strobes - s0), 32'd6);

    // Backpressure: transmitter not ready for 100 cycles while in SEND.
    tx_block = 1'b1;
    push_exp(8'hA1, 4'b0010);
    push_exp(8'h61, 4'b0010);
    enq(1, 8'h61, 1'b1);
    wait_grant(50, 4'b0010, "bp_grant");
    s0 = strobes;
    repeat (100) @(negedge i_clk);
    #1;
    check("bp_no_strobe", 32'(strobes - s0), 32'd0);
    check("bp_data_held", 32'(o_tx_data), 32'h51);
    check("bp_busy", 32'(o_busy), 32'd1);
    tx_block = 1'b0;
    @(negedge i_clk);  // transmitter ready rises here
    @(negedge i_clk);
    #1;
    check("bp_strobe_next_cycle", 32'(o_tx_en), 32'd1);
    check("bp_strobe_data", 32'(o_tx_data), 32'hA1);
    wait_idle(500, "bp_idle");

    // Timeout: req3 sends one non-last byte and then goes quiet.
    push_exp(8'hA3, 4'b1000);
    push_exp(8'h71, 4'b1000);
    enq(3, 8'h71, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge i_clk);
      #1;
      if (o_req_ready[3] === 1'b1 && sb.size() == 0) found = 1'b1;
    end
    check("to_second_load", 32'(found), 32'd1);
    a0 = aborts;
    n  = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      #1;
      n++;
      if (o_abort === 1'b1) break;
    end
    check("to_latency", 32'(n), 32'd16);
    check("to_grant_cleared", 32'(o_grant), 32'd0);
    check("to_busy_cleared", 32'(o_busy), 32'd0);
    @(negedge i_clk);
    #1;
    check("to_abort_one_cycle", 32'(o_abort), 32'd0);
    check("to_abort_count", 32'(aborts - a0), 32'd1);
    s0 = strobes;
    push_exp(8'hA0, 4'b0001); push_exp(8'h81, 4'b0001);
    push_exp(8'hA2, 4'b0100); push_exp(8'h91, 4'b0100);
    enq(0, 8'h81, 1'b1);
    enq(2, 8'h91, 1'b1);
    wait_idle(1000, "to_next_idle");
    check("to_next_strobes", 32'(strobes - s0), 32'd4);

    // Reset in WAIT mid-packet, then a fresh req0 packet.
    push_exp(8'hA1, 4'b0010);
    push_exp(8'hD1, 4'b0010);
    enq(1, 8'hD1, 1'b0);
    enq(1, 8'hD2, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge i_clk);
      #1;
      if (sb.size() == 0) found = 1'b1;
    end
    check("rst_reach_data", 32'(found), 32'd1);
    @(negedge i_clk);  // GUARD -> WAIT
    #1;
    check("rst_busy_before", 32'(o_busy), 32'd1);
    i_rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    flush_reqs();
    #3;
    i_rst_n = 1'b1;
    s0 = strobes;
    push_exp(8'hA0, 4'b0001);
    push_exp(8'hE1, 4'b0001);
    enq(0, 8'hE1, 1'b1);
    wait_idle(1000, "rst_after_idle");
    check("rst_after_strobes", 32'(strobes - s0), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
